// File: rtl/alu_flags_pkg.sv
// Shared definitions for the flag register / carry-chain tracker.
package alu_flags_pkg;

  // Z/N/H flag source select
  typedef enum logic [1:0] {
    FSEL_KEEP = 2'd0,
    FSEL_ALU  = 2'd1,
    FSEL_CLR  = 2'd2,
    FSEL_SET  = 2'd3
  } fsel_e;

  // C flag source select; codes 6 and 7 are unused and behave as KEEP
  typedef enum logic [2:0] {
    CSEL_KEEP = 3'd0,
    CSEL_ALU  = 3'd1,
    CSEL_CLR  = 3'd2,
    CSEL_SET  = 3'd3,
    CSEL_INV  = 3'd4,
    CSEL_DAA  = 3'd5
  } csel_e;

  // Tracker state
  // state   | meaning
  // IDLE    | waiting for a flag command, cmd_ready high
  // RUN     | counting nibble passes, chaining carry
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  // Resolve a two-bit flag select against the current and ALU-derived value
  function automatic logic sel_flag(input logic [1:0] sel, input logic cur, input logic alu_v);
    case (sel)
      FSEL_ALU: sel_flag = alu_v;
      FSEL_CLR: sel_flag = 1'b0;
      FSEL_SET: sel_flag = 1'b1;
      default:  sel_flag = cur;
    endcase
  endfunction

endpackage

// File: rtl/alu_flags_daa.sv
// Combinational DAA correction operand and resulting carry.
module alu_daa (
  input  logic [7:0] acc_i,
  input  logic       n_i,
  input  logic       h_i,
  input  logic       c_i,
  output logic [7:0] adj_o,
  output logic       c_o
);

  logic hi_fix;
  logic lo_fix;

  // After a subtract only the recorded carries steer the correction
  always_comb begin
    if (n_i) begin
      hi_fix = c_i;
      lo_fix = h_i;
    end else begin
      hi_fix = c_i | (acc_i > 8'h99);
      lo_fix = h_i | (acc_i[3:0] > 4'd9);
    end
    adj_o = {1'b0, hi_fix, hi_fix, 1'b0, 1'b0, lo_fix, lo_fix, 1'b0};
    c_o   = hi_fix;
  end

endmodule

// File: rtl/alu_flags.sv
// SM83 flag register and inter-pass carry tracker for the nibble-serial ALU.
module alu_flags
  import alu_flags_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_passes,
  input  logic       cmd_ci,
  input  logic [1:0] cmd_zsel,
  input  logic [1:0] cmd_nsel,
  input  logic [1:0] cmd_hsel,
  input  logic [2:0] cmd_csel,
  input  logic       pass_valid,
  input  logic [3:0] alu_res,
  input  logic       alu_co,
  output logic       alu_ci,
  input  logic [7:0] acc,
  output logic [7:0] daa_adj,
  input  logic       f_we,
  input  logic [7:0] f_din,
  output logic [7:0] flags,
  output logic       busy,
  output logic       done
);

  state_e     state_q;
  logic [2:0] npass_q;
  logic [2:0] pass_cnt_q;
  logic       chain_q;
  logic       zacc_q;
  logic       hcap_q;
  logic       done_q;
  logic [1:0] zsel_q;
  logic [1:0] nsel_q;
  logic [1:0] hsel_q;
  logic [2:0] csel_q;
  logic [7:4] f_q;

  logic [7:4] f_d;
  logic       z_alu;
  logic       last_pass;
  logic       hcap_pass;
  logic       daa_c;
  logic       f_din_unused;

  assign f_din_unused = ^f_din[3:0];

  alu_daa u_daa (
    .acc_i (acc),
    .n_i   (f_q[FLAG_N]),
    .h_i   (f_q[FLAG_H]),
    .c_i   (f_q[FLAG_C]),
    .adj_o (daa_adj),
    .c_o   (daa_c)
  );

  // Flag values that would be committed if this cycle carries the final pass
  always_comb begin
    z_alu     = zacc_q & (alu_res == 4'd0);
    last_pass = (pass_cnt_q == (npass_q - 3'd1));
    hcap_pass = (pass_cnt_q == (npass_q - 3'd2));
    f_d[FLAG_Z] = sel_flag(zsel_q, f_q[FLAG_Z], z_alu);
    f_d[FLAG_N] = sel_flag(nsel_q, f_q[FLAG_N], 1'b0);
    f_d[FLAG_H] = sel_flag(hsel_q, f_q[FLAG_H], hcap_q);
    case (csel_q)
      CSEL_ALU: f_d[FLAG_C] = alu_co;
      CSEL_CLR: f_d[FLAG_C] = 1'b0;
      CSEL_SET: f_d[FLAG_C] = 1'b1;
      CSEL_INV: f_d[FLAG_C] = ~f_q[FLAG_C];
      CSEL_DAA: f_d[FLAG_C] = daa_c;
      default:  f_d[FLAG_C] = f_q[FLAG_C];
    endcase
  end

  // Command acceptance, pass counting, carry chaining and flag commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      npass_q    <= 3'd2;
      pass_cnt_q <= 3'd0;
      chain_q    <= 1'b0;
      zacc_q     <= 1'b1;
      hcap_q     <= 1'b0;
      done_q     <= 1'b0;
      zsel_q     <= FSEL_KEEP;
      nsel_q     <= FSEL_KEEP;
      hsel_q     <= FSEL_KEEP;
      csel_q     <= CSEL_KEEP;
      f_q        <= 4'h0;
    end else begin
      done_q <= 1'b0;
      if (f_we) begin
        // Direct load also abandons any operation in flight without a commit
        f_q     <= f_din[7:4];
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_valid) begin
              state_q    <= ST_RUN;
              npass_q    <= (cmd_passes == 3'd4) ? 3'd4 : 3'd2;
              pass_cnt_q <= 3'd0;
              chain_q    <= cmd_ci;
              zacc_q     <= 1'b1;
              zsel_q     <= cmd_zsel;
              nsel_q     <= cmd_nsel;
              hsel_q     <= cmd_hsel;
              csel_q     <= cmd_csel;
            end
          end
          ST_RUN: begin
            if (pass_valid) begin
              chain_q    <= alu_co;
              zacc_q     <= z_alu;
              pass_cnt_q <= pass_cnt_q + 3'd1;
              if (hcap_pass) hcap_q <= alu_co;
              if (last_pass) begin
                f_q     <= f_d;
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign alu_ci    = chain_q;
  assign flags     = {f_q, 4'b0000};

endmodule

// File: tb/tb_alu_flags.sv
// Self-checking bench for alu_flags: command table plus corner-case sequences.
module tb_alu_flags;
  import alu_flags_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_passes;
  logic       cmd_ci;
  logic [1:0] cmd_zsel, cmd_nsel, cmd_hsel;
  logic [2:0] cmd_csel;
  logic       pass_valid;
  logic [3:0] alu_res;
  logic       alu_co;
  logic       alu_ci;
  logic [7:0] acc;
  logic [7:0] daa_adj;
  logic       f_we;
  logic [7:0] f_din;
  logic [7:0] flags;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [2:0]  passes;
    logic        ci;
    logic [1:0]  zs, ns, hs;
    logic [2:0]  cs;
    logic [7:0]  acc;
    logic [15:0] res;   // nibble of pass p at [4p+3:4p]
    logic [3:0]  co;    // carry-out of pass p at bit p
    int          gap;   // idle cycles before each pass
    logic [7:0]  exp_f;
  } vec_t;

  vec_t vecs[10];

  alu_flags dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_passes(cmd_passes), .cmd_ci(cmd_ci),
    .cmd_zsel(cmd_zsel), .cmd_nsel(cmd_nsel), .cmd_hsel(cmd_hsel), .cmd_csel(cmd_csel),
    .pass_valid(pass_valid), .alu_res(alu_res), .alu_co(alu_co), .alu_ci(alu_ci),
    .acc(acc), .daa_adj(daa_adj), .f_we(f_we), .f_din(f_din),
    .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] p, input logic ci, input logic [1:0] z, input logic [1:0] n,
                              input logic [1:0] h, input logic [2:0] c, input logic [7:0] a,
                              input logic [15:0] r, input logic [3:0] co, input int gap, input logic [7:0] ef);
    vec_t v;
    v.passes = p; v.ci = ci; v.zs = z; v.ns = n; v.hs = h; v.cs = c;
    v.acc = a; v.res = r; v.co = co; v.gap = gap; v.exp_f = ef;
    return v;
  endfunction

  function automatic logic [7:0] daa_ref(input logic [7:0] a, input logic [7:0] f);
    logic hi, lo;
    if (f[6]) begin
      hi = f[4];
      lo = f[5];
    end else begin
      hi = f[4] || (a > 8'h99);
      lo = f[5] || (a[3:0] > 4'd9);
    end
    return (hi ? 8'h60 : 8'h00) | (lo ? 8'h06 : 8'h00);
  endfunction

  // Scoreboard: each done pulse must match the oldest expected commit
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        chk("flags_commit", 32'(flags), 32'(sb.pop_front()));
      end
    end
  end

  task automatic issue(input logic [2:0] p, input logic ci, input logic [1:0] z, input logic [1:0] n,
                       input logic [1:0] h, input logic [2:0] c);
    cmd_passes = p; cmd_ci = ci; cmd_zsel = z; cmd_nsel = n; cmd_hsel = h; cmd_csel = c;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    int np;
    logic exp_ci;
    np = (v.passes == 3'd4) ? 4 : 2;
    acc = v.acc;
    issue(v.passes, v.ci, v.zs, v.ns, v.hs, v.cs);
    sb.push_back(v.exp_f);
    exp_ci = v.ci;
    for (int p = 0; p < np; p++) begin
      for (int g = 0; g < v.gap; g++) begin
        // A competing command while running must be refused
        cmd_valid = 1'b1; cmd_csel = CSEL_SET; cmd_zsel = FSEL_SET;
        chk("cmd_ready_run", 32'(cmd_ready), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("alu_ci_hold", 32'(alu_ci), 32'(exp_ci));
      end
      pass_valid = 1'b1;
      alu_res = v.res[4*p +: 4];
      alu_co = v.co[p];
      chk("alu_ci_pass", 32'(alu_ci), 32'(exp_ci));
      tick();
      pass_valid = 1'b0;
      exp_ci = v.co[p];
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_passes = 3'd2; cmd_ci = 1'b0;
    cmd_zsel = FSEL_KEEP; cmd_nsel = FSEL_KEEP; cmd_hsel = FSEL_KEEP; cmd_csel = CSEL_KEEP;
    pass_valid = 1'b0; alu_res = 4'h0; alu_co = 1'b0; acc = 8'h00; f_we = 1'b0; f_din = 8'h00;

    //              pass ci  Z          N          H          C         acc    res       co       gap flags
    vecs[0] = mk(3'd2, 0, FSEL_ALU,  FSEL_ALU,  FSEL_ALU,  CSEL_ALU,  8'h00, 16'h0000, 4'b0011, 0, 8'hB0);
    vecs[1] = mk(3'd4, 0, FSEL_KEEP, FSEL_CLR,  FSEL_ALU,  CSEL_ALU,  8'h00, 16'h1000, 4'b0111, 2, 8'hA0);
    vecs[2] = mk(3'd2, 0, FSEL_KEEP, FSEL_CLR,  FSEL_CLR,  CSEL_SET,  8'h00, 16'h0000, 4'b0000, 0, 8'h90);
    vecs[3] = mk(3'd2, 0, FSEL_KEEP, FSEL_CLR,  FSEL_CLR,  CSEL_INV,  8'h00, 16'h0000, 4'b0000, 0, 8'h80);
    vecs[4] = mk(3'd2, 0, FSEL_KEEP, FSEL_CLR,  FSEL_CLR,  CSEL_SET,  8'h00, 16'h0000, 4'b0000, 0, 8'h90);
    vecs[5] = mk(3'd2, 0, FSEL_KEEP, FSEL_SET,  FSEL_SET,  CSEL_KEEP, 8'h00, 16'h0000, 4'b0000, 0, 8'hF0);
    vecs[6] = mk(3'd2, 0, FSEL_ALU,  FSEL_KEEP, FSEL_CLR,  CSEL_DAA,  8'h00, 16'h009A, 4'b0000, 0, 8'h50);
    vecs[7] = mk(3'd3, 1, FSEL_ALU,  FSEL_ALU,  FSEL_ALU,  CSEL_ALU,  8'h00, 16'h0000, 4'b0001, 1, 8'hA0);
    vecs[8] = mk(3'd2, 0, FSEL_ALU,  FSEL_KEEP, FSEL_CLR,  CSEL_DAA,  8'h3C, 16'h0042, 4'b0000, 0, 8'h00);
    vecs[9] = mk(3'd2, 0, FSEL_ALU,  FSEL_KEEP, FSEL_CLR,  CSEL_DAA,  8'h9A, 16'h0000, 4'b0011, 0, 8'h90);

    tick(); tick();
    reset = 1'b0;
    chk("rst_flags", 32'(flags), 32'h00);
    chk("rst_alu_ci", 32'(alu_ci), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_daa_adj", 32'(daa_adj), 32'h00);

    // Pass in IDLE must not move the carry chain
    pass_valid = 1'b1; alu_co = 1'b1; alu_res = 4'h5;
    tick();
    pass_valid = 1'b0;
    chk("idle_pass_ci", 32'(alu_ci), 32'd0);
    chk("idle_pass_busy", 32'(busy), 32'd0);

    // Table: consecutive commands, each new one offered in the previous done cycle
    for (int i = 0; i < 10; i++) run_op(vecs[i]);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);

    // DAA operand against the bench model over a spread of flag states
    acc = 8'h3C; f_we = 1'b1; f_din = 8'h00; tick(); f_we = 1'b0;
    chk("daa_3c", 32'(daa_adj), 32'h06);
    acc = 8'h9A; #1;
    chk("daa_9a", 32'(daa_adj), 32'h66);
    for (int f = 0; f < 8; f++) begin
      logic [7:0] fv;
      fv = {1'b1, 3'(f), 4'h0};
      f_we = 1'b1; f_din = fv | 8'h0F; tick(); f_we = 1'b0;
      chk("fwe_low_nibble", 32'(flags), 32'(fv));
      for (int k = 0; k < 10; k++) begin
        logic [7:0] a;
        case (k)
          0: a = 8'h00; 1: a = 8'h09; 2: a = 8'h0A; 3: a = 8'h99;
          4: a = 8'h9A; 5: a = 8'hA0; 6: a = 8'hFF; default: a = 8'($urandom_range(0, 255));
        endcase
        acc = a; #1;
        chk("daa_sweep", 32'(daa_adj), 32'(daa_ref(a, fv)));
      end
    end

    // f_we in the middle of RUN aborts without commit
    issue(3'd2, 1'b0, FSEL_ALU, FSEL_ALU, FSEL_ALU, CSEL_ALU);
    pass_valid = 1'b1; alu_res = 4'h1; alu_co = 1'b0; tick(); pass_valid = 1'b0;
    f_we = 1'b1; f_din = 8'hFF; tick(); f_we = 1'b0;
    chk("abort_flags", 32'(flags), 32'hF0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_done_late", 32'(done), 32'd0);

    // f_we coinciding with the final pass wins over the commit
    issue(3'd2, 1'b0, FSEL_ALU, FSEL_ALU, FSEL_ALU, CSEL_ALU);
    pass_valid = 1'b1; alu_res = 4'h0; alu_co = 1'b1; tick();
    f_we = 1'b1; f_din = 8'h5A; tick(); f_we = 1'b0; pass_valid = 1'b0;
    chk("fwe_commit_flags", 32'(flags), 32'h50);
    chk("fwe_commit_done", 32'(done), 32'd0);
    chk("fwe_commit_busy", 32'(busy), 32'd0);

    // Reset between passes clears everything; a stray pass afterwards is ignored
    issue(3'd2, 1'b1, FSEL_ALU, FSEL_ALU, FSEL_ALU, CSEL_ALU);
    chk("ci_first_pass", 32'(alu_ci), 32'd1);
    pass_valid = 1'b1; alu_res = 4'h3; alu_co = 1'b1; tick(); pass_valid = 1'b0;
    chk("ci_chain", 32'(alu_ci), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_flags", 32'(flags), 32'h00);
    chk("midrst_alu_ci", 32'(alu_ci), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    pass_valid = 1'b1; alu_res = 4'h0; alu_co = 1'b1; tick(); pass_valid = 1'b0;
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_flags", 32'(flags), 32'h00);
    chk("post_rst_ci", 32'(alu_ci), 32'd0);

    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
